// File: rtl/fractal_pkg.sv
// Shared definitions for the fractal viewport path: Q3.13 format, reset viewport,
// saturation helper and the view_controller FSM states.
// Latency: n/a (package). Backpressure: n/a.
package fractal_pkg;

  // Q3.13 fixed point: 16-bit word, 13 fractional bits
  localparam int W    = 16;
  localparam int FRAC = 13;

  // Reset viewport: top-left at (-1.0, -1.0)
  localparam logic [W-1:0] DEF_START_X = 16'hE000;
  localparam logic [W-1:0] DEF_START_Y = 16'hE000;
  localparam logic [W-1:0] DEF_STEP_X  = 16'h0019;
  localparam logic [W-1:0] DEF_STEP_Y  = 16'h0022;

  typedef enum logic [1:0] {
    IDLE,
    PAN,
    ZOOM,
    COMMIT
  } vcState_t;

  // One captured frame's worth of requests; field order matches the
  // button vector {up, down, left, right, zoom_in, zoom_out}.
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic zoomIn;
    logic zoomOut;
  } viewCmd_t;

  // Clamp a 32-bit signed intermediate into the signed 16-bit range.
  function automatic logic signed [W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'sh7FFF;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return v[W-1:0];
  endfunction

endpackage

// File: rtl/btn_edge_latch.sv
// Per-button rise detector with a sticky pending bit per button.
// Latency: a rise is visible on pending the cycle after it is sampled.
// Backpressure: none; a rise during clear survives into the next pending set.
// Ports: clk, reset (sync, active-high), btn[N] levels, clear (drop current
//        pending bits), pending[N] captured requests.
module btn_edge_latch #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn,
  input  logic         clear,
  output logic [N-1:0] pending
);

  logic [N-1:0] btnQ;
  logic [N-1:0] rise;

  assign rise = btn & ~btnQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      btnQ    <= '0;
      pending <= '0;
    end else begin
      btnQ    <= btn;
      // Clearing only drops bits already captured; a rise in the same cycle
      // belongs to the next frame.
      pending <= (clear ? '0 : pending) | rise;
    end
  end

endmodule

// File: rtl/view_controller.sv
// Turns pan/zoom button presses into a new viewport, committed once per frame.
// Latency: outputs change 3 cycles after the VS falling edge is sampled.
// Backpressure: none; a VS fall while busy is ignored and requests stay pending.
// Ports: Clk_100M, reset (sync, active-high), VS (active-low), six debounced
//        buttons; startX/startY (signed Q3.13), stepX/stepY (unsigned Q3.13),
//        frame_update (one-cycle pulse when the outputs are written).
module view_controller
  import fractal_pkg::*;
#(
  parameter int           H_RES       = 640,
  parameter int           V_RES       = 480,
  parameter logic [W-1:0] START_X_RST = DEF_START_X,
  parameter logic [W-1:0] START_Y_RST = DEF_START_Y,
  parameter logic [W-1:0] STEP_X_RST  = DEF_STEP_X,
  parameter logic [W-1:0] STEP_Y_RST  = DEF_STEP_Y,
  parameter int           PAN_SHIFT   = 4,
  parameter logic [W-1:0] MIN_STEP    = 16'h0001,
  parameter logic [W-1:0] MAX_STEP    = 16'h0040
) (
  input  logic                Clk_100M,
  input  logic                reset,
  input  logic                VS,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_zoom_in,
  input  logic                btn_zoom_out,
  output logic signed [W-1:0] startX,
  output logic signed [W-1:0] startY,
  output logic        [W-1:0] stepX,
  output logic        [W-1:0] stepY,
  output logic                frame_update
);

  vcState_t            state;
  viewCmd_t            cmd;
  logic [5:0]          pendBits;
  logic                clearPend;
  logic                vsQ;
  logic                vsFall;
  logic signed [W-1:0] wX, wY;
  logic        [W-1:0] wStepX, wStepY;

  btn_edge_latch #(.N(6)) uLatch (
    .clk     (Clk_100M),
    .reset   (reset),
    .btn     ({btn_up, btn_down, btn_left, btn_right, btn_zoom_in, btn_zoom_out}),
    .clear   (clearPend),
    .pending (pendBits)
  );

  assign vsFall    = vsQ & ~VS;
  assign clearPend = (state == IDLE) && vsFall && (|pendBits);

  // 32-bit signed views of the working registers; steps are unsigned.
  logic signed [31:0] wX32, wY32, sX32, sY32;
  logic signed [31:0] panX, panY, zInX, zInY, zOutX, zOutY;
  logic               doIn, doOut;

  assign wX32 = {{16{wX[W-1]}}, wX};
  assign wY32 = {{16{wY[W-1]}}, wY};
  assign sX32 = {16'd0, wStepX};
  assign sY32 = {16'd0, wStepY};

  // Opposing pan buttons cancel: each direction applies only on its own.
  assign panX = wX32 + ((cmd.right && !cmd.left) ?  (sX32 <<< PAN_SHIFT) : 32'sd0)
                     - ((cmd.left && !cmd.right) ?  (sX32 <<< PAN_SHIFT) : 32'sd0);
  assign panY = wY32 + ((cmd.down && !cmd.up)    ?  (sY32 <<< PAN_SHIFT) : 32'sd0)
                     - ((cmd.up && !cmd.down)    ?  (sY32 <<< PAN_SHIFT) : 32'sd0);

  // Centre-preserving zoom: shift the corner by a quarter (in) or half (out)
  // of the visible span. Constant factors reduce to shift-add.
  assign zInX  = wX32 + sX32 * (H_RES / 4);
  assign zInY  = wY32 + sY32 * (V_RES / 4);
  assign zOutX = wX32 - sX32 * (H_RES / 2);
  assign zOutY = wY32 - sY32 * (V_RES / 2);

  assign doIn  = cmd.zoomIn && !cmd.zoomOut && (wStepX > MIN_STEP) && (wStepY > MIN_STEP);
  assign doOut = cmd.zoomOut && !cmd.zoomIn && (wStepX < MAX_STEP) && (wStepY < MAX_STEP);

  always_ff @(posedge Clk_100M) begin
    if (reset) begin
      vsQ <= 1'b0;
    end else begin
      vsQ <= VS;
    end
  end

  always_ff @(posedge Clk_100M) begin
    if (reset) begin
      state        <= IDLE;
      cmd          <= '0;
      wX           <= START_X_RST;
      wY           <= START_Y_RST;
      wStepX       <= STEP_X_RST;
      wStepY       <= STEP_Y_RST;
      startX       <= START_X_RST;
      startY       <= START_Y_RST;
      stepX        <= STEP_X_RST;
      stepY        <= STEP_Y_RST;
      frame_update <= 1'b0;
    end else begin
      frame_update <= 1'b0;
      case (state)
        IDLE: begin
          if (vsFall && (|pendBits)) begin
            cmd    <= viewCmd_t'(pendBits);
            wX     <= startX;
            wY     <= startY;
            wStepX <= stepX;
            wStepY <= stepY;
            state  <= PAN;
          end
        end
        PAN: begin
          wX    <= sat16(panX);
          wY    <= sat16(panY);
          state <= ZOOM;
        end
        ZOOM: begin
          if (doIn) begin
            wX     <= sat16(zInX);
            wY     <= sat16(zInY);
            wStepX <= wStepX >> 1;
            wStepY <= wStepY >> 1;
          end else if (doOut) begin
            wX     <= sat16(zOutX);
            wY     <= sat16(zOutY);
            wStepX <= wStepX << 1;
            wStepY <= wStepY << 1;
          end
          state <= COMMIT;
        end
        COMMIT: begin
          startX       <= wX;
          startY       <= wY;
          stepX        <= wStepX;
          stepY        <= wStepY;
          frame_update <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_view_controller.sv
module tb_view_controller;

  logic Clk_100M = 1'b0;
  logic reset = 1'b1;
  logic VS = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic btn_zoom_in = 1'b0, btn_zoom_out = 1'b0;
  logic signed [15:0] startX, startY;
  logic [15:0] stepX, stepY;
  logic frame_update;

  int testsRun = 0;
  int testsFailed = 0;
  int fuCount = 0;
  bit checkEn = 1'b0;

  always #5 Clk_100M = ~Clk_100M;

  view_controller dut (
    .Clk_100M     (Clk_100M),
    .reset        (reset),
    .VS           (VS),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_zoom_in  (btn_zoom_in),
    .btn_zoom_out (btn_zoom_out),
    .startX       (startX),
    .startY       (startY),
    .stepX        (stepX),
    .stepY        (stepY),
    .frame_update (frame_update)
  );

  logic [5:0] btnVec;
  assign btnVec = {btn_up, btn_down, btn_left, btn_right, btn_zoom_in, btn_zoom_out};

  // ---------------- behavioural model ----------------
  // Viewport as plain integers; a frame's requests are applied all at once
  // and become visible a fixed number of clocks after the VS fall.
  int mX, mY, mSX, mSY;
  int nX, nY, nSX, nSY;
  bit mFU;
  bit [5:0] mPend, mPrevBtn, mRise;
  bit mPrevVS, mFall;
  int mCnt;

  function automatic int clamp16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void computeView(bit [5:0] c);
    int x, y, sx, sy, dx, dy;
    x = mX; y = mY; sx = mSX; sy = mSY;
    dx = int'(c[2]) - int'(c[3]);   // right - left
    dy = int'(c[4]) - int'(c[5]);   // down - up
    x = clamp16(x + dx * sx * 16);
    y = clamp16(y + dy * sy * 16);
    if (c[1] && !c[0] && sx > 1 && sy > 1) begin
      x = clamp16(x + sx * 160);
      y = clamp16(y + sy * 120);
      sx = sx / 2; sy = sy / 2;
    end else if (c[0] && !c[1] && sx < 64 && sy < 64) begin
      x = clamp16(x - sx * 320);
      y = clamp16(y - sy * 240);
      sx = sx * 2; sy = sy * 2;
    end
    nX = x; nY = y; nSX = sx; nSY = sy;
  endfunction

  always @(posedge Clk_100M) begin
    if (reset) begin
      mX = -8192; mY = -8192; mSX = 25; mSY = 34;
      mFU = 1'b0; mPend = '0; mPrevBtn = '0; mPrevVS = 1'b0; mCnt = 0;
    end else begin
      mRise = btnVec & ~mPrevBtn;
      mFall = mPrevVS && !VS;
      mFU = 1'b0;
      if (mCnt > 0) begin
        mCnt = mCnt - 1;
        if (mCnt == 0) begin
          mX = nX; mY = nY; mSX = nSX; mSY = nSY; mFU = 1'b1;
        end
      end else if (mFall && mPend != 0) begin
        computeView(mPend);
        mPend = '0;
        mCnt = 3;
      end
      mPend = mPend | mRise;
      mPrevBtn = btnVec;
      mPrevVS = VS;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge Clk_100M) begin
    if (frame_update === 1'b1) fuCount++;
    if (checkEn) begin
      testsRun++;
      if ({startX, startY, stepX, stepY, frame_update} !==
          {16'(mX), 16'(mY), 16'(mSX), 16'(mSY), mFU}) begin
        testsFailed++;
        $display("FAIL model t=%0t: got %h/%h/%h/%h fu=%b, expected %h/%h/%h/%h fu=%b",
                 $time, startX, startY, stepX, stepY, frame_update,
                 16'(mX), 16'(mY), 16'(mSX), 16'(mSY), mFU);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic expectView(string name, logic [15:0] ex, logic [15:0] ey,
                            logic [15:0] esx, logic [15:0] esy);
    testsRun++;
    if ({startX, startY, stepX, stepY} !== {ex, ey, esx, esy}) begin
      testsFailed++;
      $display("FAIL %s: got %h/%h/%h/%h, expected %h/%h/%h/%h",
               name, startX, startY, stepX, stepY, ex, ey, esx, esy);
    end
  endtask

  task automatic expectInt(string name, int got, int exp);
    testsRun++;
    if (got != exp) begin
      testsFailed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge Clk_100M);
  endtask

  task automatic doReset();
    reset = 1'b1; VS = 1'b1;
    {btn_up, btn_down, btn_left, btn_right, btn_zoom_in, btn_zoom_out} = '0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  // One frame: VS low for two cycles, then long enough high for the commit.
  task automatic frame();
    VS = 1'b0; tick(2);
    VS = 1'b1; tick(8);
  endtask

  task automatic pressBtns(logic [5:0] b);
    {btn_up, btn_down, btn_left, btn_right, btn_zoom_in, btn_zoom_out} = b;
    tick(2);
    {btn_up, btn_down, btn_left, btn_right, btn_zoom_in, btn_zoom_out} = '0;
    tick(1);
  endtask

  localparam logic [5:0] B_UP = 6'b100000, B_LEFT = 6'b001000, B_RIGHT = 6'b000100;
  localparam logic [5:0] B_ZIN = 6'b000010, B_ZOUT = 6'b000001;

  initial begin
    int f0;
    tick(1);
    doReset();
    checkEn = 1'b1;

    expectView("reset_state", 16'hE000, 16'hE000, 16'h0019, 16'h0022);
    f0 = fuCount;
    repeat (3) frame();
    expectView("idle_frames", 16'hE000, 16'hE000, 16'h0019, 16'h0022);
    expectInt("idle_no_pulse", fuCount - f0, 0);

    // single right pan
    f0 = fuCount;
    pressBtns(B_RIGHT);
    frame();
    expectView("pan_right", 16'hE190, 16'hE000, 16'h0019, 16'h0022);
    expectInt("pan_right_pulses", fuCount - f0, 1);

    // held right moves only once across three frames
    f0 = fuCount;
    btn_right = 1'b1; tick(2);
    repeat (3) frame();
    btn_right = 1'b0; tick(2);
    expectView("held_right", 16'hE320, 16'hE000, 16'h0019, 16'h0022);
    expectInt("held_right_pulses", fuCount - f0, 1);

    // reset while the FSM is in PAN aborts the update
    pressBtns(B_RIGHT);
    VS = 1'b0; tick(1);
    reset = 1'b1; VS = 1'b1; tick(1);
    expectView("reset_mid_pan", 16'hE000, 16'hE000, 16'h0019, 16'h0022);
    f0 = fuCount;
    reset = 1'b0; tick(10);
    expectView("after_abort", 16'hE000, 16'hE000, 16'h0019, 16'h0022);
    expectInt("abort_no_pulse", fuCount - f0, 0);

    // zoom in from reset
    doReset();
    pressBtns(B_ZIN);
    frame();
    expectView("zoom_in", 16'hEFA0, 16'hEFF0, 16'h000C, 16'h0011);

    // zoom out five times: stepY reaches 0044 after one step, which blocks the rest
    doReset();
    pressBtns(B_ZOUT);
    frame();
    expectView("zoom_out_1", 16'hC0C0, 16'hC020, 16'h0032, 16'h0044);
    repeat (4) begin
      pressBtns(B_ZOUT);
      frame();
    end
    expectView("zoom_out_refused", 16'hC0C0, 16'hC020, 16'h0032, 16'h0044);

    // opposing pan cancels but still commits
    doReset();
    f0 = fuCount;
    pressBtns(B_LEFT | B_RIGHT);
    frame();
    expectView("left_right_cancel", 16'hE000, 16'hE000, 16'h0019, 16'h0022);
    expectInt("cancel_pulse", fuCount - f0, 1);

    // repeated pan up saturates at 8000
    doReset();
    pressBtns(B_UP);
    frame();
    expectView("pan_up_1", 16'hE000, 16'hDDE0, 16'h0019, 16'h0022);
    repeat (59) begin
      pressBtns(B_UP);
      frame();
    end
    expectView("pan_up_saturate", 16'hE000, 16'h8000, 16'h0019, 16'h0022);

    // randomized traffic, including VS falls while busy and occasional resets
    doReset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge Clk_100M);
      if ($urandom_range(0, 9) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 9) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 9) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 9) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 11) == 0) btn_zoom_in = ~btn_zoom_in;
      if ($urandom_range(0, 11) == 0) btn_zoom_out = ~btn_zoom_out;
      if ($urandom_range(0, 3) == 0) VS = ~VS;
      reset = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;
    tick(10);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2_000_000;
    testsFailed++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "watchdog");
  end

endmodule
